// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and FSM state encoding for the iterative ALU
// Purpose: op-code constants shared with the ALU control decoder, plus the
//          iter_alu state type.
// Ports:   none (package)
package alu_pkg;

  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SRL = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_ADD = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/iter_alu_if.sv
// rtl/iter_alu_if.sv - start/busy/done request bundle between controller and ALU
// Purpose: groups the ALU request and response signals.
// Ports:   master = controller side (drives start/gin/a/b/shamt),
//          slave  = ALU side (drives busy/done/result/zero).
interface iter_alu_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);

  logic               start;
  logic [2:0]         gin;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               zero;

  modport master (
    output start, gin, a, b, shamt,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, gin, a, b, shamt,
    output busy, done, result, zero
  );

endinterface

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - one-bit-per-clock shift register with countdown
// Purpose: holds the shift register, remaining count and direction for sll/srl.
// Ports:   clk, reset (sync, active-high); load captures din/amt/left;
//          shifted = shreg moved one bit in the held direction (zero fill);
//          last = high on the cycle whose edge takes the count from 1 to 0.
module serial_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               left,
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] amt,
  output logic [WIDTH-1:0]   shifted,
  output logic               last
);

  logic [WIDTH-1:0]   shreg;
  logic [SHAMT_W-1:0] cnt;
  logic               dir_left;

  assign shifted = dir_left ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  assign last    = (cnt == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      cnt      <= '0;
      dir_left <= 1'b0;
    end else if (load) begin
      shreg    <= din;
      cnt      <= amt;
      dir_left <= left;
    end else if (cnt != '0) begin
      shreg <= shifted;
      cnt   <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - ALU with single-cycle add/sub/or/nor and bit-serial sll/srl
// Purpose: executes the decoded op; shifts take shamt cycles with busy high.
// Ports:   clk, reset (sync, active-high);
//          bus (slave): start/gin/a/b/shamt in, busy/done/result/zero out.
//          done is a one-cycle pulse; result/zero hold until the next completion.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  iter_alu_if.slave   bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, res_d, single_res, sh_next;
  logic             zero_q, res_load, sh_load, sh_last, is_shift;

  assign is_shift = (bus.gin == ALU_SLL) || (bus.gin == ALU_SRL);

  serial_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (sh_load),
    .left    (bus.gin == ALU_SLL),
    .din     (bus.b),
    .amt     (bus.shamt),
    .shifted (sh_next),
    .last    (sh_last)
  );

  // Single-cycle ops; a zero-length shift just passes b through.
  always_comb begin
    single_res = '0;
    case (bus.gin)
      ALU_SLL, ALU_SRL: single_res = bus.b;
      ALU_NOR:          single_res = ~(bus.a | bus.b);
      ALU_SUB:          single_res = bus.a - bus.b;
      ALU_OR:           single_res = bus.a | bus.b;
      ALU_ADD:          single_res = bus.a + bus.b;
      default:          single_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    res_load = 1'b0;
    res_d    = '0;
    sh_load  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          if (is_shift && (bus.shamt != '0)) begin
            sh_load = 1'b1;
            state_d = SHIFT;
          end else begin
            res_load = 1'b1;
            res_d    = single_res;
            state_d  = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // start is ignored here; the shifter counts down on its own.
        if (sh_last) begin
          res_load = 1'b1;
          res_d    = sh_next;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (res_load) begin
        result_q <= res_d;
        zero_q   <= (res_d == '0);
      end
    end
  end

  assign bus.busy   = (state_q == SHIFT);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - self-checking bench for iter_alu
module tb_iter_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  iter_alu_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  iter_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected outputs from the op semantics: a shift of k completes k edges
  // after acceptance with the full b<<k / b>>k value.
  int          m_busy   = 0;
  logic        m_done   = 1'b0;
  logic [31:0] m_result = 32'h0;
  logic [31:0] m_pend   = 32'h0;
  logic        m_zero   = 1'b1;

  function automatic logic [31:0] model_op(input logic [2:0] g, input logic [31:0] a,
                                           input logic [31:0] b, input int sh);
    case (g)
      3'b001:  return b << sh;
      3'b010:  return b >> sh;
      3'b011:  return ~(a | b);
      3'b100:  return a - b;
      3'b101:  return a | b;
      3'b110:  return a + b;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] v;
    if (reset) begin
      m_busy = 0; m_done = 1'b0; m_result = 32'h0; m_zero = 1'b1;
    end else if (m_busy > 0) begin
      m_busy = m_busy - 1;
      m_done = 1'b0;
      if (m_busy == 0) begin
        m_result = m_pend; m_zero = (m_pend == 32'h0); m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (bus.start) begin
        v = model_op(bus.gin, bus.a, bus.b, int'(bus.shamt));
        if ((bus.gin == 3'b001 || bus.gin == 3'b010) && bus.shamt != 5'd0) begin
          m_busy = int'(bus.shamt);
          m_pend = v;
        end else begin
          m_result = v; m_zero = (v == 32'h0); m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_busy",   32'(bus.busy),   32'(m_busy > 0));
      chk("cmp_done",   32'(bus.done),   32'(m_done));
      chk("cmp_result", bus.result,      m_result);
      chk("cmp_zero",   32'(bus.zero),   32'(m_zero));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] g, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    bus.start = 1'b1; bus.gin = g; bus.a = a; bus.b = b; bus.shamt = sh;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0; busy_n = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) busy_n++;
      tick();
      cyc++;
    end
    if (cyc >= 100) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_100");
    end
  endtask

  int cyc, busy_n, dn;

  initial begin
    reset = 1'b1;
    bus.start = 1'b1; bus.gin = ALU_ADD; bus.a = 32'd1; bus.b = 32'd1; bus.shamt = 5'd0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_busy",   32'(bus.busy), 32'd0);
    chk("rst_done",   32'(bus.done), 32'd0);
    chk("rst_result", bus.result,    32'd0);
    chk("rst_zero",   32'(bus.zero), 32'd1);
    reset = 1'b0; bus.start = 1'b0;
    tick();
    chk("rst_no_done", 32'(bus.done), 32'd0);

    issue(ALU_ADD, 32'd7, 32'd5, 5'd0);
    chk("add_done",   32'(bus.done), 32'd1);
    chk("add_result", bus.result,    32'd12);
    chk("add_zero",   32'(bus.zero), 32'd0);
    tick();
    chk("add_done_low", 32'(bus.done), 32'd0);
    chk("add_hold",     bus.result,    32'd12);

    issue(ALU_SUB, 32'd9, 32'd9, 5'd0);
    chk("sub_eq_result", bus.result,    32'd0);
    chk("sub_eq_zero",   32'(bus.zero), 32'd1);
    tick();
    issue(ALU_SUB, 32'd0, 32'd1, 5'd0);
    chk("sub_neg", bus.result, 32'hFFFF_FFFF);
    tick();

    issue(ALU_SLL, 32'd0, 32'h1, 5'd4);
    wait_done(cyc, busy_n);
    chk("sll4_busy_cycles", 32'(busy_n), 32'd4);
    chk("sll4_latency",     32'(cyc),    32'd4);
    chk("sll4_result",      bus.result,  32'h10);
    tick();
    issue(ALU_SLL, 32'd0, 32'h1, 5'd0);
    chk("sll0_done",   32'(bus.done), 32'd1);
    chk("sll0_result", bus.result,    32'h1);
    tick();

    issue(ALU_SRL, 32'd0, 32'h8000_0000, 5'd31);
    wait_done(cyc, busy_n);
    chk("srl31_busy_cycles", 32'(busy_n), 32'd31);
    chk("srl31_result",      bus.result,  32'h1);
    tick();

    // Re-pulse start and disturb operands while shifting.
    issue(ALU_SRL, 32'd0, 32'h8000_0000, 5'd31);
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1; bus.gin = ALU_ADD; bus.a = 32'd5 + i; bus.b = 32'hFFFF_FFFF;
      bus.shamt = 5'd2;
      tick();
    end
    bus.start = 1'b0;
    wait_done(cyc, busy_n);
    dn = (bus.done === 1'b1) ? 1 : 0;
    chk("srl_ignore_result", bus.result, 32'h1);
    chk("srl_ignore_lat",    32'(cyc),   32'd28);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done === 1'b1) dn++;
    end
    chk("srl_single_done", 32'(dn), 32'd1);

    // Back-to-back accepts from DONE.
    bus.start = 1'b1; bus.gin = ALU_OR; bus.a = 32'hF0; bus.b = 32'h0F; bus.shamt = 5'd0;
    tick();
    chk("b2b_or", bus.result, 32'hFF);
    bus.gin = ALU_NOR; bus.a = 32'h0; bus.b = 32'h0;
    tick();
    chk("b2b_nor_done", 32'(bus.done), 32'd1);
    chk("b2b_nor",      bus.result,    32'hFFFF_FFFF);
    bus.gin = ALU_SLL; bus.b = 32'h3; bus.shamt = 5'd2;
    tick();
    bus.start = 1'b0;
    chk("b2b_sll_busy", 32'(bus.busy), 32'd1);
    wait_done(cyc, busy_n);
    chk("b2b_sll", bus.result, 32'd12);
    tick();

    issue(3'b000, 32'd3, 32'd4, 5'd0);
    chk("op000_result", bus.result,    32'd0);
    chk("op000_zero",   32'(bus.zero), 32'd1);
    issue(ALU_ADD, 32'd1, 32'd1, 5'd0);
    issue(3'b111, 32'd3, 32'd4, 5'd0);
    chk("op111_result", bus.result,    32'd0);
    chk("op111_zero",   32'(bus.zero), 32'd1);
    tick();

    // Reset mid-shift aborts without a done.
    issue(ALU_ADD, 32'd2, 32'd3, 5'd0);
    issue(ALU_SLL, 32'd0, 32'h5, 5'd10);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy",   32'(bus.busy), 32'd0);
    chk("abort_result", bus.result,    32'd0);
    chk("abort_zero",   32'(bus.zero), 32'd1);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1) dn++;
      tick();
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
